// File: rtl/mem_pkg.sv
// Shared types and defaults for the unified-memory arbiter and its latency counter.
package mem_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int MEM_LAT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Loadable down-counter: holds at zero, tc marks the last cycle of a countdown.
module lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch
// and data access; data wins, one access in flight at a time.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    input  logic              halt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_e            state_q, state_d;
    logic              squash_q, squash_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;

    logic dm_req, if_go;

    assign dm_req = dm_rd ^ dm_wr;
    assign if_go  = if_req & ~halt & ~if_flush;

    lat_counter #(.W(CNT_W)) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(MEM_LAT)),
        .cnt      (cnt),
        .tc       (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        squash_d  = squash_q;
        addr_d    = addr_q;
        cnt_load  = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = '0;
        if_done   = 1'b0;
        if_rdata  = '0;
        dm_done   = 1'b0;
        dm_rdata  = '0;
        err       = 1'b0;
        // Outputs are held quiet during reset so an abandoned access never reports.
        if (!rst) begin
            err = dm_rd & dm_wr;
            case (state_q)
                IDLE: begin
                    if (dm_req) begin
                        mem_en    = 1'b1;
                        mem_wr    = dm_wr;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                        addr_d    = dm_addr;
                        cnt_load  = 1'b1;
                        state_d   = BUSY_D;
                    end else if (if_go) begin
                        mem_en   = 1'b1;
                        mem_addr = if_addr;
                        addr_d   = if_addr;
                        cnt_load = 1'b1;
                        squash_d = 1'b0;
                        state_d  = BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (cnt_tc) begin
                        if_done  = ~squash_q & ~if_flush;
                        if_rdata = if_done ? mem_rdata : '0;
                        squash_d = 1'b0;
                        state_d  = IDLE;
                    end else if (if_flush) begin
                        squash_d = 1'b1;
                    end
                end
                BUSY_D: begin
                    if (cnt_tc) begin
                        dm_done  = 1'b1;
                        dm_rdata = mem_rdata;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign dm_stall = ~rst & (dm_rd | dm_wr) & ~dm_done;
    assign if_stall = ~rst & ((if_req & ~if_done & ~halt) | ((state_q != IDLE) & ~cnt_tc));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            squash_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
            addr_q   <= addr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random stimulus against a cycle-numbered transaction model.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst, if_req, if_flush, halt, dm_rd, dm_wr;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr, err;

    int errors = 0;
    int checks = 0;

    // Model: at most one access outstanding, completing on a known cycle number.
    int          cyc = 0;
    bit          m_busy = 0, m_data = 0, m_sq = 0;
    int          m_done_at = 0;
    logic [15:0] m_addr = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .halt(halt),
        .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err(err)
    );

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return a ^ 16'hA5B5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
        end
    endtask

    task automatic idle_in();
        rst = 0; if_req = 0; if_flush = 0; halt = 0; dm_rd = 0; dm_wr = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
    endtask

    // One clock: inputs already driven; checks at negedge, model advances at posedge.
    task automatic step();
        bit          comp, e_ifd, e_dmd, e_en, e_wr, e_iss_d, e_err;
        bit          e_ifs, e_dms;
        logic [15:0] e_ifr, e_dmr, e_addr, e_wd;
        comp = !rst && m_busy && (cyc == m_done_at);
        mem_rdata = comp ? memfn(m_addr) : 16'($urandom);
        e_ifd = comp && !m_data && !m_sq && !if_flush;
        e_dmd = comp && m_data;
        e_ifr = e_ifd ? memfn(m_addr) : 16'h0;
        e_dmr = e_dmd ? memfn(m_addr) : 16'h0;
        e_iss_d = !rst && !m_busy && (dm_rd ^ dm_wr);
        e_en  = e_iss_d || (!rst && !m_busy && if_req && !halt && !if_flush);
        e_wr  = e_iss_d && dm_wr;
        e_addr = e_iss_d ? dm_addr : if_addr;
        e_wd  = dm_wdata;
        e_err = !rst && dm_rd && dm_wr;
        e_dms = !rst && (dm_rd || dm_wr) && !e_dmd;
        e_ifs = !rst && ((if_req && !e_ifd && !halt) || (m_busy && !comp));
        @(negedge clk);
        chk("mem_en", mem_en, e_en);
        if (e_en) begin
            chk("mem_wr", mem_wr, e_wr);
            chk("mem_addr", mem_addr, e_addr);
            if (e_wr) chk("mem_wdata", mem_wdata, e_wd);
        end
        chk("if_done", if_done, e_ifd);
        chk("if_rdata", if_rdata, e_ifr);
        chk("dm_done", dm_done, e_dmd);
        chk("dm_rdata", dm_rdata, e_dmr);
        chk("if_stall", if_stall, e_ifs);
        chk("dm_stall", dm_stall, e_dms);
        chk("err", err, e_err);
        if (rst) begin
            m_busy = 0; m_sq = 0;
        end else begin
            if (comp) m_busy = 0;
            else if (m_busy && !m_data && if_flush) m_sq = 1;
            if (e_en) begin
                m_busy = 1; m_data = e_iss_d; m_sq = 0;
                m_addr = e_addr; m_done_at = cyc + LAT;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        idle_in(); mem_rdata = '0;
        @(posedge clk); #1;
        rst = 1; run(2);
        rst = 0;
        chk("rst_addr", mem_addr, 16'h0);
        chk("rst_en", mem_en, 1'b0);
        run(1);

        // Plain fetch, held request reissues after completion.
        if_req = 1; if_addr = 16'h0010; run(6);
        idle_in(); run(5);

        // Data beats fetch; fetch follows once data completes.
        dm_rd = 1; dm_addr = 16'h0200; if_req = 1; if_addr = 16'h0040; run(5);
        dm_rd = 0; run(6);
        idle_in(); run(4);

        // Store.
        dm_wr = 1; dm_addr = 16'h0300; dm_wdata = 16'h1234; run(5);
        idle_in(); run(2);

        // Flush during fetch squashes its completion; next fetch is normal.
        if_req = 1; if_addr = 16'h0010; run(1);
        if_addr = 16'h0020; run(1);
        if_flush = 1; run(1);
        if_flush = 0; run(7);
        idle_in(); run(5);

        // Conflicting data request with halted fetch: no issue at all.
        dm_rd = 1; dm_wr = 1; halt = 1; if_req = 1; if_addr = 16'h0050; run(3);
        idle_in(); run(1);

        // Reset in the middle of a data read.
        dm_rd = 1; dm_addr = 16'h0400; run(2);
        dm_rd = 0; rst = 1; run(1);
        rst = 0; dm_rd = 1; dm_addr = 16'h0410; run(6);
        idle_in(); run(2);

        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(99) < 2);
            if_req   = ($urandom_range(99) < 70);
            halt     = ($urandom_range(99) < 15);
            if_flush = ($urandom_range(99) < 10);
            dm_rd    = ($urandom_range(99) < 25);
            dm_wr    = ($urandom_range(99) < 20);
            if_addr  = 16'($urandom);
            dm_addr  = 16'($urandom);
            dm_wdata = 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
